icache_dm: RTL and testbench
============================

// Module: icache_dm
// PURPOSE
//   Direct-mapped, read-only instruction cache between the core's ibus port and the CBus.
//   Serves ibus_req_t fetches from a flop-array line store.
//   Refills a missing line with one CBus burst read.
//   The core holds ireq.valid/addr stable until data_ok; hits complete in the request cycle.
// PARAMETERS
//   NUM_SETS    64   lines in cache, power of 2 (index width IDX_W = $clog2(NUM_SETS))
//   LINE_WORDS  4    64-bit words per line, power of 2 (offset width OFF_W = $clog2(LINE_WORDS*8))
// PORTS
//   clk    in   1              clock
//   reset  in   1              reset, synchronous, active-high
//   ireq   in   ibus_req_t     fetch request {valid, addr[63:0]}
//   iresp  out  ibus_resp_t    {addr_ok, data_ok, data[31:0]}
//   flush  in   1              invalidate all lines (fence.i)
//   creq   out  cbus_req_t     {valid, is_write, size, addr, strobe, data, len, burst}
//   cresp  in   cbus_resp_t    {ready, last, data[63:0]}
// BEHAVIOUR
//   Address split (physical 32 bits only; addr[63:32] and addr[1:0] ignored):
//   - tag = addr[31:OFF_W+IDX_W], index = addr[OFF_W+IDX_W-1:OFF_W]
//   - word = addr[OFF_W-1:3], half select = addr[2] (0 = bits[31:0], 1 = bits[63:32])
//   Storage: valid[NUM_SETS], tag[NUM_SETS], data[NUM_SETS][LINE_WORDS] x 64.
//   - Reset clears every valid bit; tag/data are not reset.
//   Reset values of outputs: iresp = '0; creq.valid = 0, is_write = 0, strobe = 0, data = 0.
//   FSM IDLE:
//   - Hit (ireq.valid & valid[idx] & tag match & !flush): addr_ok = data_ok = 1 combinationally in the same cycle.
//   - On a hit, iresp.data = selected 32-bit half; stay IDLE.
//   - Miss (ireq.valid & !hit & !flush): go to REFILL next cycle.
//   - Latch line base = {addr[31:OFF_W], OFF_W'0}, latch idx, and clear the beat counter.
//   FSM REFILL:
//   - creq.valid = 1, addr = line base, size = MSIZE8, len = LINE_WORDS-1, burst = AXI_BURST_INCR.
//   - Each cycle with cresp.ready: data[idx][cnt] <= cresp.data, cnt++ (counter wraps to 0 on last).
//   - On ready & last: tag[idx] <= latched tag; valid[idx] <= !flush_pend; go to IDLE.
//   - iresp.data_ok = 0 for the whole of REFILL.
//   Miss latency: data_ok in the cycle after the last beat (IDLE re-lookup hits) -> total = beats + 2 cycles.
//   flush:
//   - In IDLE: all valid bits cleared next edge; no data_ok that cycle (flush beats hit).
//   - In REFILL: the burst runs to completion (CBus transactions are never abandoned).
//   - A flush during REFILL sets flush_pend, so the filled line stays invalid and all other valid bits are cleared.
//   - flush_pend is cleared on return to IDLE.
//   Reset mid-REFILL: next state IDLE, creq.valid = 0 immediately after the edge, all lines invalid, flush_pend = 0.
//   ireq.valid = 0 in IDLE: no state change, iresp = '0.
// CONFIGURATION
//   ICACHE_UNCACHED_EN defined:
//   - Fetch with addr[31] == 0 is uncached: state UNCACHED issues creq with addr = {addr[31:2], 2'b0}.
//   - The uncached request uses size = MSIZE4, len = 0, burst = AXI_BURST_FIXED.
//   - On ready & last the word is latched into a holding register; data_ok is returned next cycle in IDLE.
//   - The holding register is consumed exactly once; no line is filled, no valid bit changes.
//   ICACHE_UNCACHED_EN undefined: every address is cached; state UNCACHED and the holding register are not built.
// STRUCTURE
//   common package additions:
//   - typedef enum {IC_IDLE, IC_REFILL, IC_UNCACHED} icache_state_t
//   - ICACHE_NUM_SETS / ICACHE_LINE_WORDS default constants
//   - icache_addr_t packed struct {tag, index, offset}
//   One sub-module: icache_ram, a NUM_SETS x LINE_WORDS x 64 flop array.
//   - icache_ram has 1 async read port and 1 sync write port (word-granular).
//   FSM, tag/valid arrays and the CBus driver live in icache_dm.
// TESTING  (NUM_SETS=64, LINE_WORDS=4: index = addr[10:5], tag = addr[31:11])
//   Cold fetch:
//   - Stimulus: ireq 0x8000_0000, memory word0 = 0x0000_0013_0010_0093.
//   - Response: one burst, addr 0x8000_0000, len=3, MSIZE8.
//   - Then data_ok with 0x0010_0093 one cycle after last.
//   Sequential 0x8000_0004..0x8000_001C after the fill -> 7 same-cycle hits, creq.valid stays 0.
//   Conflict:
//   - 0x8000_0800 (idx 0, new tag) -> refill evicts the line.
//   - Refetch of 0x8000_0000 -> misses and refills again.
//   flush during beat 1 of a 0x8000_0040 refill:
//   - Response: the burst completes; the next fetch to 0x8000_0040 misses.
//   - A previously hit line at 0x8000_0000 also misses.
//   reset during beat 2:
//   - creq.valid = 0 the next cycle, state IDLE.
//   - A fetch of 0x8000_0000 misses.
//   ICACHE_UNCACHED_EN uncached fetch of 0x0000_1000 (repeated twice):
//   - With the macro: two single-beat MSIZE4 len=0 reads, no fill.
//   - Without the macro: one len=3 burst to 0x0000_1000, then a hit.

Source files
------------

// File: rtl/icache_dm_pkg.sv
// Shared types and default geometry for the direct-mapped instruction cache slice.
// Holds the ibus/CBus transaction structs used by icache_dm and its bench.
package icache_dm_pkg;

  localparam int ICACHE_NUM_SETS   = 64;
  localparam int ICACHE_LINE_WORDS = 4;
  localparam int ICACHE_IDX_W      = $clog2(ICACHE_NUM_SETS);
  localparam int ICACHE_OFF_W      = $clog2(ICACHE_LINE_WORDS * 8);

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  typedef enum logic [1:0] {
    AXI_BURST_FIXED = 2'd0,
    AXI_BURST_INCR  = 2'd1,
    AXI_BURST_WRAP  = 2'd2
  } axi_burst_t;

  typedef enum logic [1:0] {
    IC_IDLE,
    IC_REFILL,
    IC_UNCACHED
  } icache_state_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    msize_t      size;
    logic [63:0] addr;
    logic [7:0]  strobe;
    logic [63:0] data;
    logic [7:0]  len;
    axi_burst_t  burst;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;

  // Physical-address view for the default geometry.
  typedef struct packed {
    logic [31-ICACHE_IDX_W-ICACHE_OFF_W:0] tag;
    logic [ICACHE_IDX_W-1:0]               index;
    logic [ICACHE_OFF_W-1:0]               offset;
  } icache_addr_t;

endpackage

// File: rtl/icache_dm_ram.sv
// Line store for icache_dm: NUM_SETS x LINE_WORDS x 64-bit flop array,
// one asynchronous read port and one word-granular synchronous write port.
module icache_ram #(
  parameter int NUM_SETS   = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic                          clk,
  input  logic [$clog2(NUM_SETS)-1:0]   i_rdIdx,
  input  logic [$clog2(LINE_WORDS)-1:0] i_rdWord,
  output logic [63:0]                   o_rdData,
  input  logic                          i_we,
  input  logic [$clog2(NUM_SETS)-1:0]   i_wrIdx,
  input  logic [$clog2(LINE_WORDS)-1:0] i_wrWord,
  input  logic [63:0]                   i_wrData
);

  logic [63:0] r_mem [NUM_SETS][LINE_WORDS];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_wrIdx][i_wrWord] <= i_wrData;
  end

  assign o_rdData = r_mem[i_rdIdx][i_rdWord];

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache between the core ibus and the CBus.
// Optional ICACHE_UNCACHED_EN: fetches with addr[31]==0 bypass the cache as single-word reads.
module icache_dm
  import icache_dm_pkg::*;
#(
  parameter int NUM_SETS   = ICACHE_NUM_SETS,
  parameter int LINE_WORDS = ICACHE_LINE_WORDS
) (
  input  logic       clk,
  input  logic       reset,
  input  ibus_req_t  ireq,
  output ibus_resp_t iresp,
  input  logic       flush,
  output cbus_req_t  creq,
  input  cbus_resp_t cresp
);

  localparam int IDX_W  = $clog2(NUM_SETS);
  localparam int OFF_W  = $clog2(LINE_WORDS * 8);
  localparam int WORD_W = OFF_W - 3;
  localparam int TAG_W  = 32 - OFF_W - IDX_W;
  localparam int LINE_W = 32 - OFF_W;

  icache_state_t       r_state, w_nextState;
  logic [NUM_SETS-1:0] r_valid;
  logic [TAG_W-1:0]    r_tag [NUM_SETS];
  logic [LINE_W-1:0]   r_lineAddr;
  logic [WORD_W-1:0]   r_cnt;
  logic                r_flushPend;

  logic [IDX_W-1:0]  w_idx;
  logic [TAG_W-1:0]  w_tag;
  logic [WORD_W-1:0] w_word;
  logic [IDX_W-1:0]  w_fillIdx;
  logic [63:0]       w_rdData;
  logic [31:0]       w_hitData;
  logic w_cacheable, w_lookup, w_match, w_hit, w_miss, w_done, w_ramWe, w_unused;

  assign w_idx     = ireq.addr[OFF_W+IDX_W-1:OFF_W];
  assign w_tag     = ireq.addr[31:OFF_W+IDX_W];
  assign w_word    = ireq.addr[OFF_W-1:3];
  assign w_fillIdx = r_lineAddr[IDX_W-1:0];
  assign w_hitData = ireq.addr[2] ? w_rdData[63:32] : w_rdData[31:0];
  assign w_unused  = &{1'b0, ireq.addr[63:32], ireq.addr[1:0]};

`ifdef ICACHE_UNCACHED_EN
  assign w_cacheable = ireq.addr[31];
`else
  assign w_cacheable = 1'b1;
`endif

  // A flush in the lookup cycle suppresses both hit and miss handling.
  assign w_lookup = !reset && (r_state == IC_IDLE) && ireq.valid && !flush;
  assign w_match  = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_hit    = w_lookup && w_cacheable && w_match;
  assign w_miss   = w_lookup && w_cacheable && !w_match;
  assign w_done   = cresp.ready && cresp.last;

`ifdef ICACHE_UNCACHED_EN
  logic [29:0] r_ucAddr;
  logic        r_holdValid;
  logic [31:0] r_holdData;
  logic        w_ucStart, w_holdHit;

  assign w_ucStart = w_lookup && !w_cacheable && !r_holdValid;
  assign w_holdHit = !reset && (r_state == IC_IDLE) && ireq.valid && r_holdValid;

  // The holding register answers the still-pending core request exactly once.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_holdValid <= 1'b0;
    end else if ((r_state == IC_UNCACHED) && w_done) begin
      r_holdValid <= 1'b1;
      r_holdData  <= r_ucAddr[0] ? cresp.data[63:32] : cresp.data[31:0];
    end else if (w_holdHit) begin
      r_holdValid <= 1'b0;
    end
    if (w_ucStart) r_ucAddr <= ireq.addr[31:2];
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= IC_IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      IC_IDLE: begin
        if (w_miss) w_nextState = IC_REFILL;
`ifdef ICACHE_UNCACHED_EN
        else if (w_ucStart) w_nextState = IC_UNCACHED;
`endif
      end
      IC_REFILL, IC_UNCACHED: if (w_done) w_nextState = IC_IDLE;
      default: w_nextState = IC_IDLE;
    endcase
  end

  always_comb begin
    iresp   = '0;
    creq    = '0;
    w_ramWe = 1'b0;
    if (w_hit) begin
      iresp.addr_ok = 1'b1;
      iresp.data_ok = 1'b1;
      iresp.data    = w_hitData;
    end
`ifdef ICACHE_UNCACHED_EN
    if (w_holdHit) begin
      iresp.addr_ok = 1'b1;
      iresp.data_ok = 1'b1;
      iresp.data    = r_holdData;
    end
    if (!reset && (r_state == IC_UNCACHED)) begin
      creq.valid = 1'b1;
      creq.size  = MSIZE4;
      creq.addr  = {32'b0, r_ucAddr, 2'b00};
      creq.len   = 8'd0;
      creq.burst = AXI_BURST_FIXED;
    end
`endif
    if (!reset && (r_state == IC_REFILL)) begin
      creq.valid = 1'b1;
      creq.size  = MSIZE8;
      creq.addr  = {32'b0, r_lineAddr, {OFF_W{1'b0}}};
      creq.len   = 8'(LINE_WORDS - 1);
      creq.burst = AXI_BURST_INCR;
      w_ramWe    = cresp.ready;
    end
  end

  // A flush seen during a refill keeps the arriving line invalid when the burst ends.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid     <= '0;
      r_flushPend <= 1'b0;
      r_cnt       <= '0;
    end else begin
      if (w_miss) begin
        r_lineAddr <= ireq.addr[31:OFF_W];
        r_cnt      <= '0;
      end
      if ((r_state == IC_REFILL) && cresp.ready) r_cnt <= cresp.last ? '0 : r_cnt + 1'b1;
      if ((r_state == IC_REFILL) && w_done)     r_flushPend <= 1'b0;
      else if ((r_state == IC_REFILL) && flush) r_flushPend <= 1'b1;
      if (flush) r_valid <= '0;
      else if ((r_state == IC_REFILL) && w_done && !r_flushPend) r_valid[w_fillIdx] <= 1'b1;
      if ((r_state == IC_REFILL) && w_done) r_tag[w_fillIdx] <= r_lineAddr[LINE_W-1:IDX_W];
    end
  end

  icache_ram #(
    .NUM_SETS  (NUM_SETS),
    .LINE_WORDS(LINE_WORDS)
  ) u_ram (
    .clk     (clk),
    .i_rdIdx (w_idx),
    .i_rdWord(w_word),
    .o_rdData(w_rdData),
    .i_we    (w_ramWe),
    .i_wrIdx (w_fillIdx),
    .i_wrWord(r_cnt),
    .i_wrData(cresp.data)
  );

endmodule

// File: tb/tb_icache_dm.sv
// Self-checking bench for icache_dm: directed scenarios then randomized fetches checked
// against a resident-line model and a synthetic memory; follows ICACHE_UNCACHED_EN.
module tb_icache_dm;
  import icache_dm_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       flush = 1'b0;
  ibus_req_t  ireq;
  ibus_resp_t iresp;
  cbus_req_t  creq;
  cbus_resp_t cresp;

  icache_dm #(.NUM_SETS(64), .LINE_WORDS(4)) dut (
    .clk  (clk),
    .reset(reset),
    .ireq (ireq),
    .iresp(iresp),
    .flush(flush),
    .creq (creq),
    .cresp(cresp)
  );

  always #5 clk = ~clk;

  int          nCompared = 0;
  int          nMismatched = 0;
  int          stallPct = 0;
  logic [31:0] salt;

  // Memory-side bookkeeping written only by the responder process.
  int          burstCount = 0;
  logic [63:0] lastAddr = '0;
  logic [7:0]  lastLen = '0;
  msize_t      lastSize = MSIZE1;
  axi_burst_t  lastBurst = AXI_BURST_FIXED;
  int          beat = 0;
  logic        pendFire = 1'b0;
  logic        pendReset = 1'b1;
  cbus_req_t   pendReq = '0;

  // Reference model: which 32-byte line (addr[31:5]) each of the 64 sets holds.
  bit          refValid [64];
  logic [26:0] refLine [64];

  function automatic logic [63:0] memWord(input logic [31:0] a);
    logic [31:0] al;
    al = a & ~32'h7;
    if (al == 32'h8000_0000) return 64'h0000_0013_0010_0093;
    return {al ^ salt, (al * 32'h9E37_79B1) + salt};
  endfunction

  function automatic logic [31:0] memHalf(input logic [31:0] a);
    logic [63:0] w;
    w = memWord(a);
    return a[2] ? w[63:32] : w[31:0];
  endfunction

  task automatic clearModel();
    for (int s = 0; s < 64; s++) refValid[s] = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // CBus slave: decides ready/last/data just after each negedge and books the handshake next time round.
  initial begin
    cresp = '0;
    forever begin
      @(negedge clk);
      #2;
      if (pendReset) begin
        beat = 0;
      end else if (pendFire) begin
        if (beat == 0) begin
          burstCount++;
          lastAddr  = pendReq.addr;
          lastLen   = pendReq.len;
          lastSize  = pendReq.size;
          lastBurst = pendReq.burst;
        end
        beat = cresp.last ? 0 : beat + 1;
      end
      pendReset   = reset;
      cresp.ready = creq.valid && (int'($urandom_range(99)) >= stallPct);
      cresp.last  = (8'(beat) == creq.len);
      cresp.data  = memWord(32'(creq.addr) + 32'(beat * 8));
      pendFire    = cresp.ready;
      pendReq     = creq;
    end
  end

  // One fetch held until data_ok; hit/miss, data, burst shape and (without stalls) latency are checked.
  task automatic applyStimulus(input logic [31:0] addr, input string tag);
    logic        uncached, expMiss, got;
    logic [5:0]  set;
    logic [31:0] expData, expBase;
    int          startBursts, cycles, expCycles;
    uncached = 1'b0;
`ifdef ICACHE_UNCACHED_EN
    uncached = !addr[31];
`endif
    set         = addr[10:5];
    expMiss     = uncached || !(refValid[set] && refLine[set] == addr[31:5]);
    expData     = memHalf(addr);
    expBase     = uncached ? {addr[31:2], 2'b00} : {addr[31:5], 5'b0};
    expCycles   = uncached ? 3 : (expMiss ? 6 : 1);
    startBursts = burstCount;
    @(negedge clk);
    ireq.valid = 1'b1;
    ireq.addr  = {$urandom, addr[31:2], 2'($urandom_range(3))};
    got    = 1'b0;
    cycles = 0;
    while (!got && cycles < 200) begin
      #1;
      cycles++;
      if (iresp.data_ok) got = 1'b1;
      else @(negedge clk);
    end
    checkOutput($sformatf("%s_done", tag), 64'(got), 64'(1));
    if (got) begin
      checkOutput($sformatf("%s_data", tag), 64'(iresp.data), 64'(expData));
      checkOutput($sformatf("%s_addr_ok", tag), 64'(iresp.addr_ok), 64'(1));
    end
    checkOutput($sformatf("%s_bursts", tag), 64'(burstCount - startBursts), 64'(expMiss ? 1 : 0));
    if (stallPct == 0) checkOutput($sformatf("%s_latency", tag), 64'(cycles), 64'(expCycles));
    if (expMiss) begin
      checkOutput($sformatf("%s_burst_addr", tag), lastAddr, {32'h0, expBase});
      checkOutput($sformatf("%s_burst_shape", tag), {51'b0, lastLen, lastSize, lastBurst},
                  uncached ? {51'b0, 8'd0, MSIZE4, AXI_BURST_FIXED}
                           : {51'b0, 8'd3, MSIZE8, AXI_BURST_INCR});
    end
    if (expMiss && !uncached) begin
      refValid[set] = 1'b1;
      refLine[set]  = addr[31:5];
    end
    @(posedge clk);
    #1;
    ireq.valid = 1'b0;
  endtask

  initial begin
    int          n;
    int          b0;
    logic [31:0] a;
    salt = $urandom;
    ireq = '0;
    clearModel();

    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_iresp", 64'(iresp), 64'(0));
    checkOutput("reset_creq", {63'b0, creq.valid}, 64'(0));
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("idle_iresp", 64'(iresp), 64'(0));
    checkOutput("idle_creq_fields", 64'({creq.valid, creq.is_write, creq.strobe} | creq.data), 64'(0));

    $display("[TB] cold fetch and sequential hits");
    applyStimulus(32'h8000_0000, "cold");
    for (int w = 1; w < 8; w++) applyStimulus(32'h8000_0000 + 32'(w * 4), $sformatf("seq%0d", w));

    $display("[TB] conflict eviction");
    applyStimulus(32'h8000_0800, "conflict");
    applyStimulus(32'h8000_0000, "refetch");

    $display("[TB] flush in idle");
    @(negedge clk);
    ireq.valid = 1'b1;
    ireq.addr  = 64'h8000_0004;
    flush      = 1'b1;
    #1;
    checkOutput("idle_flush_no_hit", 64'({iresp.addr_ok, iresp.data_ok}), 64'(0));
    @(negedge clk);
    flush      = 1'b0;
    ireq.valid = 1'b0;
    clearModel();
    applyStimulus(32'h8000_0004, "after_idle_flush");
    applyStimulus(32'h8000_0000, "rehit");

    $display("[TB] flush during refill");
    b0 = burstCount;
    @(negedge clk);
    ireq.valid = 1'b1;
    ireq.addr  = 64'h8000_0040;
    @(negedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n = 0;
    #1;
    while (creq.valid && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput("flushed_refill_ends", 64'(n < 20), 64'(1));
    checkOutput("flushed_line_no_hit", 64'(iresp.data_ok), 64'(0));
    ireq.valid = 1'b0;
    checkOutput("flushed_refill_bursts", 64'(burstCount - b0), 64'(1));
    clearModel();
    applyStimulus(32'h8000_0040, "after_refill_flush");
    applyStimulus(32'h8000_0000, "old_line_flushed");

    $display("[TB] reset during refill");
    @(negedge clk);
    ireq.valid = 1'b1;
    ireq.addr  = 64'h8000_0060;
    repeat (3) @(negedge clk);
    reset      = 1'b1;
    ireq.valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("reset_mid_creq", {63'b0, creq.valid}, 64'(0));
    @(negedge clk);
    reset = 1'b0;
    clearModel();
    #1;
    checkOutput("post_reset_idle", {63'b0, creq.valid}, 64'(0));
    applyStimulus(32'h8000_0000, "post_reset");

    $display("[TB] low-address fetch twice");
    applyStimulus(32'h0000_1000, "low1");
    applyStimulus(32'h0000_1000, "low2");

    $display("[TB] randomized fetches with stalls");
    stallPct = 30;
    for (int i = 0; i < 80; i++) begin
      a = {1'b1, 20'h0, 11'h0};
      a[31]    = ($urandom_range(7) != 0);
      a[12:11] = 2'($urandom_range(2));
      a[6:5]   = 2'($urandom_range(3));
      a[4:2]   = 3'($urandom_range(7));
      applyStimulus(a, $sformatf("rnd%0d", i));
      if ($urandom_range(9) == 0) begin
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        clearModel();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
